aw_w_route_queue: RTL and testbench

Write-data routing queue that sits directly downstream of the write-address decoder in the AXI interconnect.
- On every accepted AW transfer it records the decoded one-hot slave select, the winning master ID and AWLEN in an in-order FIFO.
- It uses the head entry to steer the W channel (wdata/wstrb/wlast/wvalid) to the correct slave and wready back to the master.
- It pops the head entry on the last beat and checks the beat count against AWLEN.

---
 rtl/axi_ic_pkg.sv | 29 ++
 rtl/axi_ic_sync_fifo.sv | 58 +++++
 rtl/aw_w_route_queue.sv | 114 +++++++++++
 tb/tb_aw_w_route_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions: slave indices, base-address tags,
// route-entry sizing and a one-hot helper.
package axi_ic_pkg;

    localparam logic [1:0] SLAVE0_IDX  = 2'b00;
    localparam logic [1:0] SLAVE1_IDX  = 2'b01;
    localparam logic [1:0] SLAVE2_IDX  = 2'b10;
    localparam logic [1:0] SLAVE3_IDX  = 2'b11;

    localparam logic [1:0] SLAVE0_BASE = 2'b00;
    localparam logic [1:0] SLAVE1_BASE = 2'b01;
    localparam logic [1:0] SLAVE2_BASE = 2'b10;
    localparam logic [1:0] SLAVE3_BASE = 2'b11;

    localparam int unsigned ONEHOT_MAX_W = 32;

    // Width of one queued route entry {sel, id, len}.
    function automatic int unsigned route_entry_width(input int unsigned num_slaves,
                                                      input int unsigned id_w,
                                                      input int unsigned len_w);
        return num_slaves + id_w + len_w;
    endfunction

    // Keeps only the lowest set bit (zero stays zero).
    function automatic logic [ONEHOT_MAX_W-1:0] lowest_set_onehot(input logic [ONEHOT_MAX_W-1:0] v);
        return v & (~v + ONEHOT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/axi_ic_sync_fifo.sv
// Generic synchronous FIFO with register-array storage, active-low sync reset,
// full/empty/count flags and no fall-through.
module axi_ic_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aw_w_route_queue.sv
// In-order AW->W route queue: records slave select/ID/len per accepted AW and
// steers W beats from the head entry, checking beat count against AWLEN.
module aw_w_route_queue
    import axi_ic_pkg::*;
#(
    parameter int unsigned Num_OF_Masters  = 2,
    parameter int unsigned Masters_ID_Size = $clog2(Num_OF_Masters),
    parameter int unsigned Num_Of_Slaves   = 4,
    parameter int unsigned AXI4_Aw_len     = 8,
    parameter int unsigned Data_Width      = 32,
    parameter int unsigned Queue_Depth     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Num_Of_Slaves-1:0]      Q_Enables,
    input  logic [Masters_ID_Size-1:0]    AW_Master_ID,
    input  logic [AXI4_Aw_len-1:0]        AW_Len,
    input  logic                          AW_Handshake,
    output logic                          AW_Accept_En,
    output logic [Masters_ID_Size-1:0]    W_Master_ID,
    output logic                          W_Route_Valid,
    input  logic [Data_Width-1:0]         S_AXI_wdata,
    input  logic [Data_Width/8-1:0]       S_AXI_wstrb,
    input  logic                          S_AXI_wlast,
    input  logic                          S_AXI_wvalid,
    output logic                          S_AXI_wready,
    output logic [Data_Width-1:0]         M_AXI_wdata,
    output logic [Data_Width/8-1:0]       M_AXI_wstrb,
    output logic                          M_AXI_wlast,
    output logic [Num_Of_Slaves-1:0]      M_AXI_wvalid,
    input  logic [Num_Of_Slaves-1:0]      M_AXI_wready,
    output logic                          Wlast_Err,
    output logic [$clog2(Queue_Depth):0]  Queue_Count
);

    localparam int unsigned EntryW = route_entry_width(Num_Of_Slaves, Masters_ID_Size, AXI4_Aw_len);
    localparam int unsigned CntW   = AXI4_Aw_len + 1;

    logic [Num_Of_Slaves-1:0]   sel_norm;
    logic [EntryW-1:0]          push_entry;
    logic [EntryW-1:0]          head_entry;
    logic [Num_Of_Slaves-1:0]   head_sel;
    logic [Masters_ID_Size-1:0] head_id;
    logic [AXI4_Aw_len-1:0]     head_len;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       route_en;
    logic                       beat;
    logic                       pop;
    logic                       len_match;
    logic [CntW-1:0]            beat_cnt;

    // A zero select defaults to slave 0; multi-hot keeps the lowest bit.
    always_comb begin
        sel_norm = Num_Of_Slaves'(lowest_set_onehot(ONEHOT_MAX_W'(Q_Enables)));
        if (Q_Enables == '0) begin
            sel_norm = Num_Of_Slaves'(1);
        end
    end

    assign push_entry = {sel_norm, AW_Master_ID, AW_Len};
    assign {head_sel, head_id, head_len} = head_entry;

    axi_ic_sync_fifo #(
        .Width (EntryW),
        .Depth (Queue_Depth)
    ) u_route_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (AW_Handshake),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (Queue_Count)
    );

    assign AW_Accept_En  = !fifo_full;
    assign W_Route_Valid = !fifo_empty;
    assign W_Master_ID   = head_id;

    // Routing is suppressed while empty and during the reset cycle.
    assign route_en     = rst && !fifo_empty;
    assign M_AXI_wvalid = route_en ? (head_sel & {Num_Of_Slaves{S_AXI_wvalid}}) : '0;
    assign S_AXI_wready = route_en && |(head_sel & M_AXI_wready);
    assign M_AXI_wdata  = S_AXI_wdata;
    assign M_AXI_wstrb  = S_AXI_wstrb;
    assign M_AXI_wlast  = S_AXI_wlast;

    assign beat      = S_AXI_wvalid && S_AXI_wready;
    assign pop       = beat && S_AXI_wlast;
    assign len_match = (beat_cnt == CntW'(head_len));

    // Beat counter and one-cycle error pulse for short/long bursts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt  <= '0;
            Wlast_Err <= 1'b0;
        end else begin
            Wlast_Err <= beat && (S_AXI_wlast ? !len_match : len_match);
            if (pop) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + CntW'(1);
            end
        end
    end

    // AW while full is dropped by the FIFO; flag it in simulation.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(AW_Handshake && fifo_full))
        else $warning("aw_w_route_queue: AW handshake while queue full, entry dropped");

endmodule

// File: tb/tb_aw_w_route_queue.sv
// Directed bench for aw_w_route_queue: one task per scenario with inline checks.
module tb_aw_w_route_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  Q_Enables;
    logic [0:0]  AW_Master_ID;
    logic [7:0]  AW_Len;
    logic        AW_Handshake;
    logic        AW_Accept_En;
    logic [0:0]  W_Master_ID;
    logic        W_Route_Valid;
    logic [31:0] S_AXI_wdata;
    logic [3:0]  S_AXI_wstrb;
    logic        S_AXI_wlast;
    logic        S_AXI_wvalid;
    logic        S_AXI_wready;
    logic [31:0] M_AXI_wdata;
    logic [3:0]  M_AXI_wstrb;
    logic        M_AXI_wlast;
    logic [3:0]  M_AXI_wvalid;
    logic [3:0]  M_AXI_wready;
    logic        Wlast_Err;
    logic [2:0]  Queue_Count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aw_w_route_queue dut (
        .clk           (clk),
        .rst           (rst),
        .Q_Enables     (Q_Enables),
        .AW_Master_ID  (AW_Master_ID),
        .AW_Len        (AW_Len),
        .AW_Handshake  (AW_Handshake),
        .AW_Accept_En  (AW_Accept_En),
        .W_Master_ID   (W_Master_ID),
        .W_Route_Valid (W_Route_Valid),
        .S_AXI_wdata   (S_AXI_wdata),
        .S_AXI_wstrb   (S_AXI_wstrb),
        .S_AXI_wlast   (S_AXI_wlast),
        .S_AXI_wvalid  (S_AXI_wvalid),
        .S_AXI_wready  (S_AXI_wready),
        .M_AXI_wdata   (M_AXI_wdata),
        .M_AXI_wstrb   (M_AXI_wstrb),
        .M_AXI_wlast   (M_AXI_wlast),
        .M_AXI_wvalid  (M_AXI_wvalid),
        .M_AXI_wready  (M_AXI_wready),
        .Wlast_Err     (Wlast_Err),
        .Queue_Count   (Queue_Count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] sel, input logic [0:0] id, input logic [7:0] len);
        Q_Enables    = sel;
        AW_Master_ID = id;
        AW_Len       = len;
        AW_Handshake = 1'b1;
        step();
        AW_Handshake = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_checks++; if (Queue_Count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", Queue_Count); end
        n_checks++; if (AW_Accept_En !== 1'b1) begin n_fail++; $display("FAIL reset_accept got=%b exp=1", AW_Accept_En); end
        n_checks++; if (W_Route_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_route_valid got=%b exp=0", W_Route_Valid); end
        n_checks++; if (Wlast_Err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", Wlast_Err); end
        S_AXI_wvalid = 1'b1;
        #1;
        n_checks++; if (M_AXI_wvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_wvalid got=%b exp=0000", M_AXI_wvalid); end
        n_checks++; if (S_AXI_wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready got=%b exp=0", S_AXI_wready); end
        S_AXI_wvalid = 1'b0;
    endtask

    task automatic test_single_burst();
        push(4'b0100, 1'b1, 8'd3);
        n_checks++; if (Queue_Count !== 3'd1) begin n_fail++; $display("FAIL burst_count_push got=%0d exp=1", Queue_Count); end
        n_checks++; if (W_Master_ID !== 1'b1) begin n_fail++; $display("FAIL burst_master_id got=%b exp=1", W_Master_ID); end
        for (int b = 0; b < 4; b++) begin
            S_AXI_wvalid = 1'b1;
            S_AXI_wlast  = (b == 3);
            S_AXI_wdata  = 32'hA000_0000 + 32'(b);
            S_AXI_wstrb  = 4'hF;
            #1;
            n_checks++; if (M_AXI_wvalid !== 4'b0100) begin n_fail++; $display("FAIL burst_wvalid beat=%0d got=%b exp=0100", b, M_AXI_wvalid); end
            n_checks++; if (S_AXI_wready !== 1'b1) begin n_fail++; $display("FAIL burst_wready beat=%0d got=%b exp=1", b, S_AXI_wready); end
            n_checks++; if (M_AXI_wdata !== 32'hA000_0000 + 32'(b)) begin n_fail++; $display("FAIL burst_wdata beat=%0d got=%h", b, M_AXI_wdata); end
            step();
            S_AXI_wvalid = 1'b0;
            S_AXI_wlast  = 1'b0;
            n_checks++; if (Wlast_Err !== 1'b0) begin n_fail++; $display("FAIL burst_err beat=%0d got=%b exp=0", b, Wlast_Err); end
        end
        n_checks++; if (Queue_Count !== 3'd0) begin n_fail++; $display("FAIL burst_count_pop got=%0d exp=0", Queue_Count); end
        n_checks++; if (W_Route_Valid !== 1'b0) begin n_fail++; $display("FAIL burst_route_valid got=%b exp=0", W_Route_Valid); end
    endtask

    task automatic test_fill();
        push(4'b0001, 1'b0, 8'd0);
        push(4'b0010, 1'b1, 8'd0);
        push(4'b0100, 1'b0, 8'd0);
        push(4'b1000, 1'b1, 8'd0);
        n_checks++; if (Queue_Count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", Queue_Count); end
        n_checks++; if (AW_Accept_En !== 1'b0) begin n_fail++; $display("FAIL fill_accept got=%b exp=0", AW_Accept_En); end
        S_AXI_wvalid = 1'b1;
        S_AXI_wlast  = 1'b1;
        #1;
        n_checks++; if (M_AXI_wvalid !== 4'b0001) begin n_fail++; $display("FAIL fill_head0 got=%b exp=0001", M_AXI_wvalid); end
        step();
        n_checks++; if (AW_Accept_En !== 1'b1) begin n_fail++; $display("FAIL fill_accept_after_pop got=%b exp=1", AW_Accept_En); end
        n_checks++; if (M_AXI_wvalid !== 4'b0010) begin n_fail++; $display("FAIL fill_head1 got=%b exp=0010", M_AXI_wvalid); end
        n_checks++; if (W_Master_ID !== 1'b1) begin n_fail++; $display("FAIL fill_head1_id got=%b exp=1", W_Master_ID); end
        S_AXI_wvalid = 1'b0;
        S_AXI_wlast  = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp_order [3];
        exp_order[0] = 4'b1000;
        exp_order[1] = 4'b0001;
        exp_order[2] = 4'b0010;
        push(4'b0001, 1'b0, 8'd0);
        n_checks++; if (Queue_Count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", Queue_Count); end
        // push while full is dropped, pop still happens
        Q_Enables = 4'b0100; AW_Len = 8'd0; AW_Handshake = 1'b1;
        S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b1;
        step();
        AW_Handshake = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        n_checks++; if (Queue_Count !== 3'd3) begin n_fail++; $display("FAIL full_drop_count got=%0d exp=3", Queue_Count); end
        // push and pop at count 3 keep the count
        Q_Enables = 4'b0010; AW_Len = 8'd0; AW_Handshake = 1'b1;
        S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b1;
        step();
        AW_Handshake = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        n_checks++; if (Queue_Count !== 3'd3) begin n_fail++; $display("FAIL pushpop_count got=%0d exp=3", Queue_Count); end
        for (int k = 0; k < 3; k++) begin
            S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b1;
            #1;
            n_checks++; if (M_AXI_wvalid !== exp_order[k]) begin n_fail++; $display("FAIL wrap_order idx=%0d got=%b exp=%b", k, M_AXI_wvalid, exp_order[k]); end
            step();
        end
        S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        n_checks++; if (Queue_Count !== 3'd0) begin n_fail++; $display("FAIL wrap_drain_count got=%0d exp=0", Queue_Count); end
    endtask

    task automatic test_empty_latency();
        S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b1;
        #1;
        n_checks++; if (S_AXI_wready !== 1'b0) begin n_fail++; $display("FAIL empty_wready got=%b exp=0", S_AXI_wready); end
        n_checks++; if (M_AXI_wvalid !== 4'b0000) begin n_fail++; $display("FAIL empty_wvalid got=%b exp=0000", M_AXI_wvalid); end
        Q_Enables = 4'b0100; AW_Len = 8'd0; AW_Handshake = 1'b1;
        #1;
        n_checks++; if (S_AXI_wready !== 1'b0) begin n_fail++; $display("FAIL no_fallthrough got=%b exp=0", S_AXI_wready); end
        step();
        AW_Handshake = 1'b0;
        #1;
        n_checks++; if (M_AXI_wvalid !== 4'b0100) begin n_fail++; $display("FAIL latency_wvalid got=%b exp=0100", M_AXI_wvalid); end
        n_checks++; if (S_AXI_wready !== 1'b1) begin n_fail++; $display("FAIL latency_wready got=%b exp=1", S_AXI_wready); end
        step();
        S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        n_checks++; if (Queue_Count !== 3'd0) begin n_fail++; $display("FAIL latency_pop_count got=%0d exp=0", Queue_Count); end
        n_checks++; if (Wlast_Err !== 1'b0) begin n_fail++; $display("FAIL latency_err got=%b exp=0", Wlast_Err); end
    endtask

    task automatic test_wlast_err();
        push(4'b0010, 1'b0, 8'd1);
        S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b1;
        step();
        S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        n_checks++; if (Wlast_Err !== 1'b1) begin n_fail++; $display("FAIL early_wlast_err got=%b exp=1", Wlast_Err); end
        n_checks++; if (Queue_Count !== 3'd0) begin n_fail++; $display("FAIL early_wlast_pop got=%0d exp=0", Queue_Count); end
        step();
        n_checks++; if (Wlast_Err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got=%b exp=0", Wlast_Err); end
        push(4'b1000, 1'b1, 8'd0);
        S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b0;
        step();
        S_AXI_wvalid = 1'b0;
        n_checks++; if (Wlast_Err !== 1'b1) begin n_fail++; $display("FAIL overrun_err got=%b exp=1", Wlast_Err); end
        n_checks++; if (Queue_Count !== 3'd1) begin n_fail++; $display("FAIL overrun_held got=%0d exp=1", Queue_Count); end
        step();
        n_checks++; if (Wlast_Err !== 1'b0) begin n_fail++; $display("FAIL overrun_pulse_width got=%b exp=0", Wlast_Err); end
        // late wlast (beat 2 of a 1-beat burst) still pops and flags
        S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b1;
        step();
        S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        n_checks++; if (Wlast_Err !== 1'b1) begin n_fail++; $display("FAIL late_wlast_err got=%b exp=1", Wlast_Err); end
        n_checks++; if (Queue_Count !== 3'd0) begin n_fail++; $display("FAIL late_wlast_pop got=%0d exp=0", Queue_Count); end
    endtask

    task automatic test_reset_mid();
        push(4'b0010, 1'b0, 8'd3);
        push(4'b0100, 1'b1, 8'd0);
        S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b0;
        step();
        rst = 1'b0;
        #1;
        n_checks++; if (M_AXI_wvalid !== 4'b0000) begin n_fail++; $display("FAIL rst_cycle_wvalid got=%b exp=0000", M_AXI_wvalid); end
        step();
        rst = 1'b1;
        #1;
        n_checks++; if (Queue_Count !== 3'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", Queue_Count); end
        n_checks++; if (M_AXI_wvalid !== 4'b0000) begin n_fail++; $display("FAIL midrst_wvalid got=%b exp=0000", M_AXI_wvalid); end
        n_checks++; if (S_AXI_wready !== 1'b0) begin n_fail++; $display("FAIL midrst_wready got=%b exp=0", S_AXI_wready); end
        S_AXI_wvalid = 1'b0;
        push(4'b0000, 1'b0, 8'd0);
        S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b1;
        #1;
        n_checks++; if (M_AXI_wvalid !== 4'b0001) begin n_fail++; $display("FAIL zero_sel_route got=%b exp=0001", M_AXI_wvalid); end
        step();
        S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        n_checks++; if (Wlast_Err !== 1'b0) begin n_fail++; $display("FAIL post_rst_beatcnt_err got=%b exp=0", Wlast_Err); end
        push(4'b0110, 1'b0, 8'd0);
        S_AXI_wvalid = 1'b1; S_AXI_wlast = 1'b1;
        #1;
        n_checks++; if (M_AXI_wvalid !== 4'b0010) begin n_fail++; $display("FAIL multihot_route got=%b exp=0010", M_AXI_wvalid); end
        step();
        S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        n_checks++; if (Queue_Count !== 3'd0) begin n_fail++; $display("FAIL final_count got=%0d exp=0", Queue_Count); end
    endtask

    initial begin
        rst          = 1'b1;
        Q_Enables    = '0;
        AW_Master_ID = '0;
        AW_Len       = '0;
        AW_Handshake = 1'b0;
        S_AXI_wdata  = '0;
        S_AXI_wstrb  = '0;
        S_AXI_wlast  = 1'b0;
        S_AXI_wvalid = 1'b0;
        M_AXI_wready = 4'b1111;
        test_reset();
        test_single_burst();
        test_fill();
        test_full_push_pop();
        test_empty_latency();
        test_wlast_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
